// File: rtl/axis_forwarder_ctrl_if.sv
// Forwarder read-port and egress AXI4-Stream bundle.
// The master modport is the sequencer side; slave is the memory/sink side.
interface axis_forwarder_ctrl_if #(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64,
    parameter int PLEN_WIDTH           = SNOOP_FWD_ADDR_WIDTH + 1
);
    logic                            ready_for_forwarder;
    logic [PLEN_WIDTH-1:0]           len_to_forwarder;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr;
    logic                            forwarder_rd_en;
    logic [DATA_WIDTH-1:0]           forwarder_rd_data;
    logic                            forwarder_done;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
    logic                            m_axis_tlast;

    modport master (
        input  ready_for_forwarder, len_to_forwarder,
        input  forwarder_rd_data, m_axis_tready,
        output forwarder_rd_addr, forwarder_rd_en, forwarder_done,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output ready_for_forwarder, len_to_forwarder,
        output forwarder_rd_data, m_axis_tready,
        input  forwarder_rd_addr, forwarder_rd_en, forwarder_done,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/axis_forwarder_ctrl.sv
// Forwarder sequencer: reads an assigned packet buffer word by word and
// streams it out as AXI4-Stream with backpressure, then pulses done.
module axis_forwarder_ctrl #(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64,
    parameter int PLEN_WIDTH           = SNOOP_FWD_ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_forwarder_ctrl_if.master io_bus
);
    localparam int AW = SNOOP_FWD_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int PW = PLEN_WIDTH;
    localparam logic [PW-1:0] MAX_LEN = PW'(2 ** AW);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [1:0]    r_state;
    logic [PW-1:0] r_len_q;
    logic [PW-1:0] r_rd_ptr;
    logic [AW-1:0] r_addr;
    logic          r_inflight;
    logic          r_infl_last;
    logic [DW-1:0] r_fifo_data [2];
    logic [1:0]    r_fifo_last;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic          w_stream;
    logic          w_fifo_ne;
    logic          w_valid;
    logic [DW-1:0] w_head_data;
    logic          w_head_last;
    logic          w_pop;
    logic          w_fifo_pop;
    logic          w_push;
    logic [2:0]    w_occ;
    logic          w_rd_en;
    logic [PW-1:0] w_len_clamped;

    // The word arriving from memory this cycle is visible at the output
    // immediately (bypass), so the first beat appears one cycle after rd_en.
    assign w_stream    = (r_state == S_STREAM);
    assign w_fifo_ne   = (r_count != 2'd0);
    assign w_valid     = w_stream & (w_fifo_ne | r_inflight);
    assign w_head_data = w_fifo_ne ? r_fifo_data[r_rptr]
                                   : io_bus.forwarder_rd_data;
    assign w_head_last = w_fifo_ne ? r_fifo_last[r_rptr] : r_infl_last;
    assign w_pop       = w_valid & io_bus.m_axis_tready;
    assign w_fifo_pop  = w_pop & w_fifo_ne;
    assign w_push      = r_inflight & ~(w_pop & ~w_fifo_ne);
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight}
                       - {2'b00, w_pop};
    assign w_rd_en     = w_stream & (r_rd_ptr < r_len_q) & (w_occ < 3'd2);
    assign w_len_clamped = (io_bus.len_to_forwarder > MAX_LEN)
                         ? MAX_LEN : io_bus.len_to_forwarder;

    assign io_bus.forwarder_rd_en   = w_rd_en;
    assign io_bus.forwarder_rd_addr = w_rd_en ? r_rd_ptr[AW-1:0] : r_addr;
    assign io_bus.forwarder_done    = (r_state == S_DONE);
    assign io_bus.m_axis_tvalid     = w_valid;
    assign io_bus.m_axis_tdata      = w_valid ? w_head_data : '0;
    assign io_bus.m_axis_tlast      = w_valid & w_head_last;

    // Packet sequencing: accept a buffer, stream it, pulse done, settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len_q  <= '0;
            r_rd_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.ready_for_forwarder) begin
                        r_len_q  <= w_len_clamped;
                        r_rd_ptr <= '0;
                        r_state  <= (w_len_clamped == '0) ? S_DONE
                                                          : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
                    if (w_pop & w_head_last) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_GAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Track the read in flight and hold the address between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
            r_addr      <= '0;
        end else begin
            r_inflight  <= w_rd_en;
            r_infl_last <= w_rd_en & (r_rd_ptr == r_len_q - PW'(1));
            if (w_rd_en) r_addr <= r_rd_ptr[AW-1:0];
        end
    end

    // Two-entry output FIFO absorbing read data while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= io_bus.forwarder_rd_data;
                r_fifo_last[r_wptr] <= r_infl_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_fifo_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
        end
    end
endmodule

// File: tb/tb_axis_forwarder_ctrl.sv
// Self-checking bench for axis_forwarder_ctrl: directed packet sequence
// with random data/backpressure against a beat-list reference model.
module tb_axis_forwarder_ctrl;
    localparam int AW   = 9;
    localparam int DW   = 64;
    localparam int PW   = AW + 1;
    localparam int MAXW = 2 ** AW;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [DW-1:0] mem [MAXW];
    logic [5:0] pat = 6'b101001;

    always #5 clk = ~clk;

    axis_forwarder_ctrl_if #(
        .SNOOP_FWD_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) bus ();

    axis_forwarder_ctrl #(
        .SNOOP_FWD_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus.master)
    );

    // Packet memory: registered read, data valid the cycle after rd_en.
    always @(posedge clk)
        if (bus.forwarder_rd_en)
            bus.forwarder_rd_data <= mem[bus.forwarder_rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAXW; i++) mem[i] = {$urandom, $urandom};
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_en"}, 64'(bus.forwarder_rd_en), 64'd0);
        chk({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
        chk({tag, "_done"}, 64'(bus.forwarder_done), 64'd0);
    endtask

    // Runs one buffer from the IDLE negedge. mode: 0 tready=1,
    // 1 fixed toggle pattern, 2 random. abort_at>=0 stops after that
    // many accepted beats (left mid-packet for a reset).
    task automatic run_packet(input int len, input int mode,
                              input int abort_at, input bit keep_ready);
        int eff, issued, beats, dones, k, k_rd, k_val, k_last, pop;
        logic [DW-1:0] prev_d;
        logic prev_l, prev_stall;
        bit aborted;
        eff = (len > MAXW) ? MAXW : len;
        issued = 0; beats = 0; dones = 0;
        k_rd = -1; k_val = -1; k_last = -1;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        aborted = 1'b0;
        bus.len_to_forwarder    = PW'(len);
        bus.ready_for_forwarder = 1'b1;
        for (k = 0; k < 4000; k++) begin
            case (mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = pat[k % 6];
                default: bus.m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop = int'(bus.m_axis_tvalid & bus.m_axis_tready);
            if (bus.forwarder_rd_en) begin
                if (k_rd < 0) k_rd = k;
                chk("rd_addr", 64'(bus.forwarder_rd_addr), 64'(issued));
                chk("rd_in_range", 64'(issued < eff), 64'd1);
                issued++;
                chk("occupancy_le2", 64'((issued - beats - pop) <= 2),
                    64'd1);
            end
            if (bus.m_axis_tvalid) begin
                if (k_val < 0) k_val = k;
                if (prev_stall) begin
                    chk("stall_tdata", bus.m_axis_tdata, prev_d);
                    chk("stall_tlast", 64'(bus.m_axis_tlast), 64'(prev_l));
                end
                if (pop != 0) begin
                    chk("tdata", bus.m_axis_tdata, mem[beats % MAXW]);
                    chk("tlast", 64'(bus.m_axis_tlast),
                        64'(beats == eff - 1));
                    beats++;
                    k_last = k;
                end
            end
            prev_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
            prev_d     = bus.m_axis_tdata;
            prev_l     = bus.m_axis_tlast;
            if (bus.forwarder_done) begin
                dones++;
                if (!keep_ready) bus.ready_for_forwarder = 1'b0;
                break;
            end
            if (abort_at >= 0 && beats == abort_at) begin
                aborted = 1'b1;
                break;
            end
            tick();
        end
        if (!aborted) begin
            chk("done_seen", 64'(dones), 64'd1);
            chk("beat_count", 64'(beats), 64'(eff));
            chk("read_count", 64'(issued), 64'(eff));
            if (eff > 0) begin
                chk("lat_rd_en", 64'(k_rd), 64'd1);
                chk("lat_tvalid", 64'(k_val), 64'd2);
                chk("done_after_last", 64'(k - k_last), 64'd1);
            end else begin
                chk("len0_no_rd", 64'(k_rd), 64'(-1));
                chk("len0_no_tvalid", 64'(k_val), 64'(-1));
                chk("len0_done_at", 64'(k), 64'd1);
            end
            tick();
            #1;
            chk_quiet("gap");
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ready_for_forwarder = 1'b0;
        bus.len_to_forwarder    = '0;
        bus.m_axis_tready       = 1'b0;
        bus.forwarder_rd_data   = '0;
        fill_random();
        #1;
        chk("rst_rd_addr", 64'(bus.forwarder_rd_addr), 64'd0);
        chk("rst_tdata", bus.m_axis_tdata, 64'd0);
        chk("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk_quiet("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < MAXW; i++) mem[i] = 64'(i + 'h100);
        run_packet(4, 0, -1, 1'b0);

        fill_random();
        run_packet(6, 1, -1, 1'b0);

        run_packet(0, 0, -1, 1'b0);

        fill_random();
        run_packet(512, 0, -1, 1'b0);

        fill_random();
        run_packet(1023, 2, -1, 1'b0);

        fill_random();
        run_packet(8, 0, 3, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.ready_for_forwarder = 1'b0;
        #1;
        chk("arst_rd_addr", 64'(bus.forwarder_rd_addr), 64'd0);
        chk("arst_tdata", bus.m_axis_tdata, 64'd0);
        chk("arst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk_quiet("arst");
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("arst_no_done", 64'(bus.forwarder_done), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        fill_random();
        run_packet(2, 0, -1, 1'b0);

        fill_random();
        run_packet(3, 0, -1, 1'b1);
        run_packet(2, 0, -1, 1'b0);

        for (int p = 0; p < 6; p++) begin
            fill_random();
            run_packet(int'($urandom_range(1, 20)), 2, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
